// File: rtl/imem_program_loader.sv
// imem_program_loader
// Writer side of the instruction store. Takes a framed big-endian byte
// stream (4 header bytes, then count*4 data bytes) over a valid/ready
// handshake and packs it into 32-bit words. Each word is written to
// instruction memory at consecutive addresses. The core is held until the
// load completes, and fetch is then given a start PC.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready  byte stream handshake
//   reload                  start a new load (honoured only in DONE)
//   imem_wr_en/addr/data    one-cycle instruction memory write port
//   pc_start                fetch start byte address (start_word*4)
//   core_hold               hold for fetch/decode/pipes
//   load_done               load finished (success or error)
//   range_err               sticky: header range was invalid
//
// State  | meaning
// -------+-------------------------------------------------------------
// HDR    | collecting the 4 header bytes (start_word, count)
// DATA   | packing data bytes and writing one word per 4 bytes
// DRAIN  | bad header range: swallowing count*4 bytes, no writes
// DONE   | load finished; release core unless range_err; wait for reload

module imem_program_loader #(
    parameter int IMEM_WORDS = 2048,
    parameter int ADDR_W     = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [0:31]       imem_wr_data,
    output logic [0:31]       pc_start,
    output logic              core_hold,
    output logic              load_done,
    output logic              range_err
);

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_DATA  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [16:0] DEPTH_17 = 17'(IMEM_WORDS);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        hdr_cnt;
    logic [23:0]       hdr_sr;
    logic [1:0]        byte_idx;
    logic [23:0]       word_sr;
    logic [17:0]       rem_cnt;
    logic [ADDR_W-1:0] addr_ptr;

    logic              accept;
    logic              hdr_last;
    logic              rem_last;
    logic [15:0]       hdr_start;
    logic [15:0]       hdr_count;
    logic [16:0]       hdr_end;
    logic              hdr_ok;

    assign in_ready  = !reset && (state != S_DONE);
    assign accept    = in_valid && in_ready;
    assign hdr_last  = (hdr_cnt == 2'd3);
    assign rem_last  = (rem_cnt == 18'd1);

    // The fourth header byte is still on in_data when the header is decoded.
    assign hdr_start = hdr_sr[23:8];
    assign hdr_count = {hdr_sr[7:0], in_data};
    assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_count};
    assign hdr_ok    = ({1'b0, hdr_start} < DEPTH_17) && (hdr_end <= DEPTH_17);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR: begin
                if (accept && hdr_last) begin
                    if (hdr_count == 16'd0) begin
                        state_nxt = S_DONE;
                    end else if (!hdr_ok) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA, S_DRAIN: begin
                if (accept && rem_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (reload) begin
                    state_nxt = S_HDR;
                end
            end
            default: state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hdr_cnt      <= 2'd0;
            hdr_sr       <= 24'd0;
            byte_idx     <= 2'd0;
            word_sr      <= 24'd0;
            rem_cnt      <= 18'd0;
            addr_ptr     <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= 32'd0;
            pc_start     <= 32'd0;
            core_hold    <= 1'b1;
            load_done    <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            imem_wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    S_HDR: begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                        hdr_sr  <= {hdr_sr[15:0], in_data};
                        if (hdr_last) begin
                            pc_start <= {14'd0, hdr_start, 2'b00};
                            addr_ptr <= hdr_start[ADDR_W-1:0];
                            rem_cnt  <= {hdr_count, 2'b00};
                            byte_idx <= 2'd0;
                            if (!hdr_ok) begin
                                range_err <= 1'b1;
                            end
                            if (hdr_count == 16'd0) begin
                                load_done <= 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        word_sr  <= {word_sr[15:0], in_data};
                        rem_cnt  <= rem_cnt - 18'd1;
                        if (byte_idx == 2'd3) begin
                            imem_wr_en   <= 1'b1;
                            imem_wr_addr <= addr_ptr;
                            imem_wr_data <= {word_sr, in_data};
                            addr_ptr     <= addr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                        if (rem_last) begin
                            load_done <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        rem_cnt <= rem_cnt - 18'd1;
                        if (rem_last) begin
                            load_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state == S_DONE) begin
                if (reload) begin
                    load_done <= 1'b0;
                    core_hold <= 1'b1;
                    range_err <= 1'b0;
                end else if (load_done && !range_err) begin
                    // One cycle after load_done so the last write lands first.
                    core_hold <= 1'b0;
                end
            end
        end
    end

endmodule
